integrator_sample_frontend: RTL
===============================

# integrator_sample_frontend

Serial sample front end feeding the integrator core. It captures signed samples from an external SPI-style link (sclk/cs_n/mosi), buffers them in a small FIFO, and re-times them onto the integrator's `sample_strobe`/`sample_in` pair as single-cycle pulses at a programmable minimum spacing. Spacing is guaranteed, so every strobe is a clean rising edge for the downstream edge detector.

## Interface
- `IN_W`, 8: sample width; must match the integrator's `IN_W`.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DIV_W`, 8: width of `pace_div`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `enable`  in  1  strobe generator run enable
- `flag_clr`  in  1  synchronous clear of sticky flags
- `spi_sclk`  in  1  serial clock, asynchronous to `clk`; must be ≤ `clk`/4
- `spi_cs_n`  in  1  frame select, active-low, asynchronous
- `spi_mosi`  in  1  serial data, MSB first, sampled on `spi_sclk` rising edge
- `pace_div`  in  DIV_W  minimum strobe period in `clk` cycles
- `sample_strobe`  out  1  one-cycle pulse; connects to the integrator `sample_strobe`
- `sample_out`  out  IN_W  signed sample; connects to the integrator `sample_in`
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  current occupancy
- `overrun_flag`  out  1  sticky: a word was dropped because the FIFO was full
- `frame_err_flag`  out  1  sticky: `cs_n` rose with a partial word
- `parity_err_flag`  out  1  sticky: parity mismatch; constant 0 without the macro

## Operation
- **Synchronisers.** `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchroniser. An sclk rise is detected as synced sclk=1 with its previous value=0.
- **Framing.**
  - A synced `cs_n` falling edge clears the bit counter and the shift register.
  - While `cs_n`=0, each sclk rise shifts synced mosi into the shift register LSB and increments the bit counter.
  - When the counter reaches WORD_BITS, the word is complete: one push request, and the counter returns to 0. Multiple words per frame are allowed.
  - WORD_BITS = IN_W, or IN_W+1 with parity.
  - A synced `cs_n` rising edge with the bit counter ≠ 0 discards the partial word and sets `frame_err_flag`.
  - sclk rises while `cs_n`=1 are ignored.
- **FIFO.**
  - Push when not full. Push when full: the word is dropped, the FIFO is unchanged, and `overrun_flag` is set.
  - A push and a pop in the same cycle while full: both take effect, with no overrun.
  - A push and a pop in the same cycle while empty: the pushed word is not popped that cycle.
- **Pacing.**
  - Counter `pcnt` saturates at its maximum value. Effective period P = max(`pace_div`, 2).
  - While `enable`=1, `pcnt` increments each cycle.
  - When `pcnt` ≥ P-1 and the FIFO is non-empty: pop, register the head into `sample_out`, assert `sample_strobe` for exactly one cycle, and reset `pcnt` to 0.
  - While `enable`=0, `pcnt` holds, no pops occur, `sample_strobe`=0, and capture continues.
- **Output hold.** `sample_out` changes only in the cycle `sample_strobe`=1 and holds between strobes.
- **Flags.** Sticky until `flag_clr`. A set event in the same cycle as `flag_clr` wins.
- **Reset values.**
  - All outputs 0: `sample_strobe`=0, `sample_out`=0, `fifo_level`=0, all flags 0.
  - `pcnt` resets to its maximum value, so the first available word may strobe immediately.
  - Reset mid-frame discards the partial word and FIFO contents. The next capture starts at the next `cs_n` fall.

## Timing
- Capture latency: the last sclk rise at the pin reaches the synchroniser output 2 cycles later. Edge detect plus push adds 1 cycle. `fifo_level` updates in the following cycle (≈4 `clk` cycles total, ±1 for synchroniser phase).
- Pop latency: FIFO non-empty and `pcnt` ≥ P-1 in cycle N gives `sample_strobe`=1 and the new `sample_out` in cycle N+1. Data is valid in the same cycle as the strobe.
- Strobe spacing: consecutive strobes are ≥P cycles apart, so `sample_strobe` is low for at least one cycle between pulses.
- `fifo_level` is registered and reflects pushes/pops of the previous cycle.
- Sustained throughput: one word per P cycles. Words arriving faster than that overrun once the FIFO fills.

## Configuration
- `SAMPLE_PARITY_EN` defined:
  - WORD_BITS = IN_W+1; the final bit is even parity over the IN_W data bits.
  - On mismatch the word is not pushed, `parity_err_flag` is set, and `overrun_flag` is unaffected.
- `SAMPLE_PARITY_EN` undefined:
  - WORD_BITS = IN_W and no parity logic is built.
  - `parity_err_flag` is tied 0.

## Test plan
- **Single word.** `pace_div`=4, `enable`=1, one frame sending 0x85 → exactly one `sample_strobe` pulse, `sample_out`=-123 (0x85) and held afterwards, `fifo_level` returns to 0.
- **Pacing.** Back-to-back frame of 4 words (1, 2, 3, -1), `pace_div`=10 → four strobes exactly 10 cycles apart, in order. With `pace_div`=0 → spacing is 2 cycles and strobe is low between pulses.
- **Overrun.** `enable`=0, send FIFO_DEPTH+1=5 words → `fifo_level`=4, `overrun_flag`=1. Then `enable`=1 → the first 4 words emerge and the 5th is lost. `flag_clr` → flag returns to 0.
- **Partial frame.** `cs_n` rises after 5 bits → `frame_err_flag`=1, no push. The next full frame with 0x7F yields `sample_out`=127.
- **Reset mid-operation.** Assert `rst_n` low with 2 words buffered and mid-frame → all outputs 0 immediately. After release, a new frame with 0x01 produces one strobe with `sample_out`=1.
- **Parity (`SAMPLE_PARITY_EN`).** Word 0x03 with parity 0 → pushed. Word 0x03 with parity 1 → dropped, `parity_err_flag`=1, no strobe.

Source files
------------

// File: rtl/integrator_sample_frontend.sv
// Serial sample capture, FIFO buffering and paced single-cycle strobe generation for the integrator.
// Build macro SAMPLE_PARITY_EN: each serial word carries a trailing even-parity bit.
module integrator_sample_frontend #(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        flag_clr,
  input  logic                        spi_sclk,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  input  logic [DIV_W-1:0]            pace_div,
  output logic                        sample_strobe,
  output logic signed [IN_W-1:0]      sample_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun_flag,
  output logic                        frame_err_flag,
  output logic                        parity_err_flag
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
`ifdef SAMPLE_PARITY_EN
  localparam int unsigned WORD_BITS = IN_W + 1;
`else
  localparam int unsigned WORD_BITS = IN_W;
`endif
  localparam int unsigned SW  = WORD_BITS - 1;
  localparam int unsigned BCW = $clog2(WORD_BITS + 1);

  // Synchroniser chains: [0] first stage, [1] synced value, [2] previous synced value
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  logic           in_frame_q, in_frame_d;
  logic [BCW-1:0] bitcnt_q, bitcnt_d;
  logic [SW-1:0]  shreg_q, shreg_d;
  logic           push_req_q, push_req_d;
  logic [IN_W-1:0] push_data_q, push_data_d;

  logic [IN_W-1:0] mem_q [FIFO_DEPTH];
  logic [IN_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;

  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic             strobe_q, strobe_d;
  logic [IN_W-1:0]  sample_q, sample_d;
  logic             overrun_q, overrun_d;
  logic             frame_q, frame_d;

  logic            sclk_rise, cs_fall, cs_rise, mosi_s;
  logic [WORD_BITS-1:0] word;
  logic [IN_W-1:0] word_data;
  logic            word_ok;
  logic            word_done;
  logic            frame_evt;
  logic            full, empty, pace_hit, do_pop, do_push, overrun_evt;
  logic [DIV_W-1:0] p_eff;

  always_comb begin : sync_comb
    sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];
  assign word      = {shreg_q, mosi_s};

`ifdef SAMPLE_PARITY_EN
  assign word_data = word[WORD_BITS-1:1];
  assign word_ok   = ~^word;
`else
  assign word_data = word;
  assign word_ok   = 1'b1;
`endif

  // Framing: a word is only assembled inside a frame opened by an observed cs_n fall
  always_comb begin : capture_comb
    in_frame_d  = in_frame_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    push_data_d = push_data_q;
    word_done   = 1'b0;
    frame_evt   = 1'b0;
    if (cs_fall) begin
      in_frame_d = 1'b1;
      bitcnt_d   = '0;
      shreg_d    = '0;
    end else if (cs_rise) begin
      in_frame_d = 1'b0;
      frame_evt  = (bitcnt_q != '0);
      bitcnt_d   = '0;
      shreg_d    = '0;
    end else if (in_frame_q && sclk_rise) begin
      if (bitcnt_q == BCW'(WORD_BITS - 1)) begin
        word_done = 1'b1;
        bitcnt_d  = '0;
        shreg_d   = '0;
        if (word_ok) begin
          push_data_d = word_data;
        end
      end else begin
        bitcnt_d = bitcnt_q + BCW'(1);
        shreg_d  = {shreg_q[SW-2:0], mosi_s};
      end
    end
    push_req_d = word_done & word_ok;
  end

  assign full     = (count_q == LW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign p_eff    = (pace_div < DIV_W'(2)) ? DIV_W'(2) : pace_div;
  assign pace_hit = (pcnt_q >= (p_eff - DIV_W'(1)));
  assign do_pop   = enable & ~empty & pace_hit;
  // A pop in the same cycle frees the slot, so a push while full is not an overrun then
  assign do_push     = push_req_q & (~full | do_pop);
  assign overrun_evt = push_req_q & full & ~do_pop;

  always_comb begin : fifo_pace_comb
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pcnt_d   = pcnt_q;
    sample_d = sample_q;
    strobe_d = do_pop;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      sample_d = mem_q[rd_ptr_q];
      pcnt_d   = '0;
    end else if (enable && (pcnt_q != '1)) begin
      pcnt_d = pcnt_q + DIV_W'(1);
    end
    count_d   = count_q + LW'(do_push) - LW'(do_pop);
    overrun_d = overrun_evt | (overrun_q & ~flag_clr);
    frame_d   = frame_evt | (frame_q & ~flag_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_ff
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      in_frame_q  <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      push_req_q  <= 1'b0;
      push_data_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pcnt_q    <= '1;
      strobe_q  <= 1'b0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      in_frame_q  <= in_frame_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      push_req_q  <= push_req_d;
      push_data_q <= push_data_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pcnt_q      <= pcnt_d;
      strobe_q    <= strobe_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
      frame_q     <= frame_d;
    end
  end

`ifdef SAMPLE_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin : parity_comb
    parity_d = (word_done & ~word_ok) | (parity_q & ~flag_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin : parity_ff
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_err_flag = parity_q;
`else
  assign parity_err_flag = 1'b0;
`endif

  assign sample_strobe  = strobe_q;
  assign sample_out     = sample_q;
  assign fifo_level     = count_q;
  assign overrun_flag   = overrun_q;
  assign frame_err_flag = frame_q;

endmodule
